icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
//  Sequences icache miss handling: NORMAL -> REFILL -> FINISH. On a cached miss it issues an AXI4 read burst
//  for the 256-bit line, writes beats into the data SRAM write port and installs the tag in a victim way.
//  On an uncached fetch it issues a single-beat read and returns the word directly.
//  Sits between the icache lookup stage and the AXI read master. Stalls fetch while busy.
// PARAMETERS
//  WAY_NUM      2    number of ways; the victim way is chosen among these
//  WORD_SIZE    64   SRAM word width, equal to the AXI data width
//  DATA_DEPTH   128  sets per way; set index = paddr[11:5]
//  BLOCK_SIZE   256  line bits; WPL = BLOCK_SIZE/WORD_SIZE = 4 beats
// PORTS
//  clk              in   1      clock
//  rst_n            in   1      asynchronous reset, active low
//  flush_i          in   1      pipeline flush; suppresses the pending response
//  miss_valid_i     in   1      miss request; held until accepted
//  miss_ready_o     out  1      request accepted (IDLE only)
//  miss_paddr_i     in   32     physical fetch address
//  miss_uncache_i   in   1      1 = uncached fetch (mat[0]==0)
//  busy_o           out  1      controller not in IDLE; feeds stall_i; blocks commit port-1 requests
//  resp_valid_o     out  1      fetched word valid, 1-cycle pulse
//  resp_data_o      out  64     word at miss_paddr_i[31:3]
//  resp_err_o       out  1      the AXI response was not OKAY; qualified by resp_valid_o
//  arvalid_o/arready_i  out/in  1   AXI AR handshake
//  araddr_o         out  32     AR address
//  arlen_o          out  8      burst length minus 1: 3 for cached, 0 for uncached
//  arsize_o         out  3      3'b011 (8 bytes)
//  arburst_o        out  2      burst type; depends on the optional feature
//  rvalid_i/rready_o in/out 1   AXI R handshake; rready_o = 1 in state R
//  rdata_i          in   64     R data
//  rresp_i          in   2      R response
//  rlast_i          in   1      last beat
//  rf_data_we_o     out  WAY_NUM  per-way data write enable, strb implied all-ones
//  rf_data_addr_o   out  9      data SRAM address paddr[11:3]
//  rf_data_o        out  64     data SRAM write data (registered rdata_i)
//  rf_tag_we_o      out  WAY_NUM  per-way tag write enable
//  rf_tag_addr_o    out  7      tag SRAM index paddr[11:5]
//  rf_tag_o         out  21     {valid=1, ppn=paddr[31:12]}
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; victim pointer=0; flush-pending=0.
//  FSM states: IDLE, AR, R, TAG, FINISH.
//  IDLE: miss_ready_o=1. When miss_valid_i=1: latch paddr and uncache, go to AR. Accepted only if flush_i=0.
//  AR: arvalid_o=1, stable until arready_i=1, then go to R.
//  R: on each rvalid_i beat, if cached, write that beat to rf_data_addr_o={idx, beat_off} in the latched
//   victim way. beat_off advances mod WPL (2-bit wrap). OR rresp_i!=OKAY into a sticky err flag.
//   Capture the beat whose offset equals paddr[4:3] into resp_data_o. On rlast_i: uncached -> FINISH, cached -> TAG.
//   If rlast_i arrives with the beat count != arlen+1, treat it as err.
//  TAG: one cycle, rf_tag_we_o=victim one-hot, only if err=0. Then advance victim pointer (round robin mod WAY_NUM).
//   Then go to FINISH.
//  FINISH: resp_valid_o=1 for one cycle unless flush-pending or the word was already delivered. Then go to IDLE.
//  Latency (no AXI wait states): miss accepted at T -> AR at T+1 -> beats T+2..T+5 -> TAG T+6 -> resp T+7.
//  flush_i mid-operation: the AXI transaction is never aborted; all beats are drained and the line is still
//   installed, but the response is suppressed (flush-pending set until IDLE).
//  flush_i in the same cycle as miss_valid_i: the request is not accepted.
//  rvalid_i stalls: no SRAM write that cycle. An R beat in the same cycle as TAG is impossible (rready_o=0).
//  Reset mid-burst: state returns to IDLE. The AXI interconnect is reset by the same rst_n.
// CONFIGURATION
//  ICACHE_REFILL_CWF_EN defined: critical word first.
//   araddr_o = paddr & ~7, arburst_o = WRAP (2'b10); the first beat writes offset paddr[4:3].
//   resp_valid_o pulses the cycle after the first beat (early restart). FINISH then emits no second pulse.
//   busy_o stays high until IDLE.
//  Not defined: araddr_o = paddr & ~31, arburst_o = INCR (2'b01), beats start at offset 0.
//   The response comes only in FINISH.
//  Uncached requests: araddr_o = paddr & ~7, arburst_o = INCR, in either configuration.
// STRUCTURE
//  Shared package: icache_refill_state_e, cache_tag_t (valid+ppn), AXI burst/size/resp constants,
//   WPL and index/offset bit-range localparams.
//  Sub-module icache_victim_sel: round-robin pointer, advance input, one-hot way output.
// TESTING
//  Cached miss paddr=0x1C00_0048, no waits -> araddr=0x1C00_0040 (non-CWF), arlen=3.
//   Data addrs 0x008..0x00B in way0. Tag idx 0x02 = {1,0x1C000}. resp_data = beat 1 at T+7.
//  Second miss to the same set -> victim way1; third miss -> way0 (wraps).
//  Uncached paddr=0x1FE0_0004 -> arlen=0, no rf_*_we. resp_data=rdata, resp_valid 1 cycle after rlast.
//  rresp=SLVERR on beat 2 -> 4 data writes occur, no tag write, resp_err_o=1, victim pointer unchanged.
//  flush_i during beat 1 with rvalid gaps -> all 4 beats written, tag written, no resp_valid_o, returns to IDLE.
//  CWF build, paddr offset 3 -> araddr=...0x18, WRAP, writes 3,0,1,2, single resp pulse after the first beat.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// Shared types and constants for the icache refill controller and its victim selector.
package icache_refill_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StTag,
    StFinish
  } icache_refill_state_e;

  typedef struct packed {
    logic        valid;
    logic [19:0] ppn;
  } cache_tag_t;

  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [1:0] AxiBurstWrap = 2'b10;
  localparam logic [2:0] AxiSize8B    = 3'b011;
  localparam logic [1:0] AxiRespOkay  = 2'b00;

  // Line geometry: 4 words per line, word offset paddr[4:3], set index paddr[11:5].
  localparam int unsigned Wpl    = 4;
  localparam int unsigned OffLsb = 3;
  localparam int unsigned OffMsb = 4;
  localparam int unsigned IdxLsb = 5;
  localparam int unsigned IdxMsb = 11;
  localparam int unsigned PpnLsb = 12;

  // Burst type used for a line refill.
  function automatic logic [1:0] line_burst(input logic cwf);
    return cwf ? AxiBurstWrap : AxiBurstIncr;
  endfunction

  // Valid tag entry for the page that holds paddr.
  function automatic cache_tag_t make_tag(input logic [31:0] paddr);
    cache_tag_t t;
    t.valid = 1'b1;
    t.ppn   = paddr[31:PpnLsb];
    return t;
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_victim_sel.sv
// Round-robin victim way selector: one-hot way output, advances on request.
module icache_victim_sel #(
  parameter int unsigned WayNum = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_advance,
  output logic [WayNum-1:0] o_way_oh
);

  localparam int unsigned PtrW = (WayNum > 1) ? $clog2(WayNum) : 1;

  logic [PtrW-1:0] r_ptr;

  // Pointer steps to the next way after each installed line, wrapping at WayNum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (r_ptr == PtrW'(WayNum - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  // Decode the pointer to a one-hot way select.
  always_comb begin
    o_way_oh        = '0;
    o_way_oh[r_ptr] = 1'b1;
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache miss sequencer between the lookup stage and the AXI read master.
// Build option ICACHE_REFILL_CWF_EN: critical-word-first WRAP bursts with early restart.
module icache_refill_ctrl
  import icache_refill_pkg::*;
#(
  parameter int unsigned WAY_NUM    = 2,
  parameter int unsigned WORD_SIZE  = 64,
  parameter int unsigned DATA_DEPTH = 128,
  parameter int unsigned BLOCK_SIZE = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic                            miss_valid_i,
  output logic                            miss_ready_o,
  input  logic [31:0]                     miss_paddr_i,
  input  logic                            miss_uncache_i,
  output logic                            busy_o,
  output logic                            resp_valid_o,
  output logic [WORD_SIZE-1:0]            resp_data_o,
  output logic                            resp_err_o,
  output logic                            arvalid_o,
  input  logic                            arready_i,
  output logic [31:0]                     araddr_o,
  output logic [7:0]                      arlen_o,
  output logic [2:0]                      arsize_o,
  output logic [1:0]                      arburst_o,
  input  logic                            rvalid_i,
  output logic                            rready_o,
  input  logic [WORD_SIZE-1:0]            rdata_i,
  input  logic [1:0]                      rresp_i,
  input  logic                            rlast_i,
  output logic [WAY_NUM-1:0]              rf_data_we_o,
  output logic [$clog2(DATA_DEPTH*Wpl)-1:0] rf_data_addr_o,
  output logic [WORD_SIZE-1:0]            rf_data_o,
  output logic [WAY_NUM-1:0]              rf_tag_we_o,
  output logic [$clog2(DATA_DEPTH)-1:0]   rf_tag_addr_o,
  output logic [$bits(cache_tag_t)-1:0]   rf_tag_o
);

`ifdef ICACHE_REFILL_CWF_EN
  localparam logic CwfEn = 1'b1;
`else
  localparam logic CwfEn = 1'b0;
`endif

  localparam logic [7:0] CachedLen = 8'(BLOCK_SIZE / WORD_SIZE - 1);

  icache_refill_state_e     r_state;
  logic [31:0]              r_paddr;
  logic                     r_uncache;
  logic                     r_err;
  logic                     r_flush_pend;
  logic                     r_delivered;
  logic [WAY_NUM-1:0]       r_victim_oh;
  logic [$clog2(Wpl)-1:0]   r_beat_off;
  logic [7:0]               r_beat_cnt;

  logic                     w_accept;
  logic                     w_beat_hit;
  logic                     w_err_next;
  logic                     w_flushed;
  logic                     w_advance;
  logic [WAY_NUM-1:0]       w_victim_oh;

  assign w_accept   = (r_state == StIdle) && miss_valid_i && miss_ready_o && !flush_i;
  assign w_beat_hit = (r_beat_off == r_paddr[OffMsb:OffLsb]);
  // A short or long burst (rlast at the wrong beat) is reported like a bus error.
  assign w_err_next = r_err | (rresp_i != AxiRespOkay) | (rlast_i & (r_beat_cnt != arlen_o));
  assign w_flushed  = r_flush_pend | flush_i;
  // Only a successfully installed line consumes the victim way.
  assign w_advance  = (r_state == StTag) && (|rf_tag_we_o);

  icache_victim_sel #(
    .WayNum(WAY_NUM)
  ) u_victim_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_advance(w_advance),
    .o_way_oh (w_victim_oh)
  );

  // Refill FSM with all outputs registered; pulses are set on the edge entering their cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_paddr        <= '0;
      r_uncache      <= 1'b0;
      r_err          <= 1'b0;
      r_flush_pend   <= 1'b0;
      r_delivered    <= 1'b0;
      r_victim_oh    <= '0;
      r_beat_off     <= '0;
      r_beat_cnt     <= '0;
      miss_ready_o   <= 1'b0;
      busy_o         <= 1'b0;
      resp_valid_o   <= 1'b0;
      resp_data_o    <= '0;
      resp_err_o     <= 1'b0;
      arvalid_o      <= 1'b0;
      araddr_o       <= '0;
      arlen_o        <= '0;
      arsize_o       <= '0;
      arburst_o      <= '0;
      rready_o       <= 1'b0;
      rf_data_we_o   <= '0;
      rf_data_addr_o <= '0;
      rf_data_o      <= '0;
      rf_tag_we_o    <= '0;
      rf_tag_addr_o  <= '0;
      rf_tag_o       <= '0;
    end else begin
      rf_data_we_o <= '0;
      rf_tag_we_o  <= '0;
      resp_valid_o <= 1'b0;
      if ((r_state != StIdle) && flush_i) begin
        r_flush_pend <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          miss_ready_o <= !w_accept;
          if (w_accept) begin
            r_paddr     <= miss_paddr_i;
            r_uncache   <= miss_uncache_i;
            r_victim_oh <= w_victim_oh;
            r_err       <= 1'b0;
            r_delivered <= 1'b0;
            r_beat_cnt  <= '0;
            // Incrementing line bursts start at word 0; every other burst starts at the fetched word.
            r_beat_off  <= (miss_uncache_i || CwfEn) ? miss_paddr_i[OffMsb:OffLsb] : '0;
            arvalid_o   <= 1'b1;
            araddr_o    <= (miss_uncache_i || CwfEn) ? {miss_paddr_i[31:3], 3'b000}
                                                     : {miss_paddr_i[31:5], 5'b00000};
            arlen_o     <= miss_uncache_i ? 8'd0 : CachedLen;
            arsize_o    <= AxiSize8B;
            arburst_o   <= miss_uncache_i ? AxiBurstIncr : line_burst(CwfEn);
            busy_o      <= 1'b1;
            r_state     <= StAr;
          end
        end
        StAr: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            r_state   <= StR;
          end
        end
        StR: begin
          if (rvalid_i) begin
            r_beat_off     <= r_beat_off + 1'b1;
            r_beat_cnt     <= r_beat_cnt + 8'd1;
            r_err          <= w_err_next;
            rf_data_o      <= rdata_i;
            rf_data_addr_o <= {r_paddr[IdxMsb:IdxLsb], r_beat_off};
            if (!r_uncache) begin
              rf_data_we_o <= r_victim_oh;
            end
            if (w_beat_hit) begin
              resp_data_o <= rdata_i;
            end
            // Early restart: hand the critical word to fetch as soon as it lands.
            if (CwfEn && !r_uncache && w_beat_hit && !w_flushed) begin
              resp_valid_o <= 1'b1;
              resp_err_o   <= w_err_next;
              r_delivered  <= 1'b1;
            end
            if (rlast_i) begin
              rready_o <= 1'b0;
              if (r_uncache) begin
                if (!w_flushed && !r_delivered) begin
                  resp_valid_o <= 1'b1;
                  resp_err_o   <= w_err_next;
                end
                r_state <= StFinish;
              end else begin
                if (!w_err_next) begin
                  rf_tag_we_o <= r_victim_oh;
                end
                rf_tag_addr_o <= r_paddr[IdxMsb:IdxLsb];
                rf_tag_o      <= make_tag(r_paddr);
                r_state       <= StTag;
              end
            end
          end
        end
        StTag: begin
          if (!w_flushed && !r_delivered) begin
            resp_valid_o <= 1'b1;
            resp_err_o   <= r_err;
          end
          r_state <= StFinish;
        end
        StFinish: begin
          busy_o       <= 1'b0;
          miss_ready_o <= 1'b1;
          r_flush_pend <= 1'b0;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed and randomized misses against an AXI slave
// and a transaction-level model (victim round robin, burst order, response rules).
`timescale 1ns/1ps
module tb_icache_refill_ctrl;

  localparam int unsigned WayNum = 2;
`ifdef ICACHE_REFILL_CWF_EN
  localparam bit Cwf = 1'b1;
`else
  localparam bit Cwf = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush_i = 1'b0;
  logic              miss_valid_i = 1'b0;
  logic              miss_ready_o;
  logic [31:0]       miss_paddr_i = '0;
  logic              miss_uncache_i = 1'b0;
  logic              busy_o;
  logic              resp_valid_o;
  logic [63:0]       resp_data_o;
  logic              resp_err_o;
  logic              arvalid_o;
  logic              arready_i = 1'b0;
  logic [31:0]       araddr_o;
  logic [7:0]        arlen_o;
  logic [2:0]        arsize_o;
  logic [1:0]        arburst_o;
  logic              rvalid_i = 1'b0;
  logic              rready_o;
  logic [63:0]       rdata_i = '0;
  logic [1:0]        rresp_i = '0;
  logic              rlast_i = 1'b0;
  logic [WayNum-1:0] rf_data_we_o;
  logic [8:0]        rf_data_addr_o;
  logic [63:0]       rf_data_o;
  logic [WayNum-1:0] rf_tag_we_o;
  logic [6:0]        rf_tag_addr_o;
  logic [20:0]       rf_tag_o;

  icache_refill_ctrl #(
    .WAY_NUM   (WayNum),
    .WORD_SIZE (64),
    .DATA_DEPTH(128),
    .BLOCK_SIZE(256)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .miss_valid_i  (miss_valid_i),
    .miss_ready_o  (miss_ready_o),
    .miss_paddr_i  (miss_paddr_i),
    .miss_uncache_i(miss_uncache_i),
    .busy_o        (busy_o),
    .resp_valid_o  (resp_valid_o),
    .resp_data_o   (resp_data_o),
    .resp_err_o    (resp_err_o),
    .arvalid_o     (arvalid_o),
    .arready_i     (arready_i),
    .araddr_o      (araddr_o),
    .arlen_o       (arlen_o),
    .arsize_o      (arsize_o),
    .arburst_o     (arburst_o),
    .rvalid_i      (rvalid_i),
    .rready_o      (rready_o),
    .rdata_i       (rdata_i),
    .rresp_i       (rresp_i),
    .rlast_i       (rlast_i),
    .rf_data_we_o  (rf_data_we_o),
    .rf_data_addr_o(rf_data_addr_o),
    .rf_data_o     (rf_data_o),
    .rf_tag_we_o   (rf_tag_we_o),
    .rf_tag_addr_o (rf_tag_addr_o),
    .rf_tag_o      (rf_tag_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WayNum-1:0] way;
    logic [8:0]        addr;
    logic [63:0]       data;
  } dwr_t;
  typedef struct packed {
    logic [WayNum-1:0] way;
    logic [6:0]        addr;
    logic [20:0]       tag;
  } twr_t;
  typedef struct packed {
    logic [63:0] data;
    logic        err;
    logic [31:0] cyc;
  } rsp_t;

  dwr_t        q_dw[$];
  twr_t        q_tw[$];
  rsp_t        q_rsp[$];
  logic [31:0] cyc = '0;
  int          n_vec = 0;
  int          n_miss = 0;
  int          vp = 0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Record every SRAM write and response pulse seen on the DUT outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|rf_data_we_o) q_dw.push_back('{rf_data_we_o, rf_data_addr_o, rf_data_o});
      if (|rf_tag_we_o) q_tw.push_back('{rf_tag_we_o, rf_tag_addr_o, rf_tag_o});
      if (resp_valid_o) q_rsp.push_back('{resp_data_o, resp_err_o, cyc});
    end
  end

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hC0DE_0000, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One miss end to end. err_beat / flush_beat < 0 mean none; timing checks zero-wait latency.
  task automatic run_miss(input logic [31:0] pa, input bit unc, input int arw, input int gap,
                          input int err_beat, input int flush_beat, input bit timing);
    logic [31:0]       exp_araddr;
    logic [31:0]       exp_ba[4];
    logic [1:0]        exp_burst;
    logic [WayNum-1:0] exp_way;
    logic [31:0]       t_acc;
    int                nb, beat, n;
    bit                any_err, exp_rsp, exp_err, hs, install;
    q_dw.delete();
    q_tw.delete();
    q_rsp.delete();
    nb         = unc ? 1 : 4;
    exp_burst  = (!unc && Cwf) ? 2'b10 : 2'b01;
    exp_araddr = (unc || Cwf) ? {pa[31:3], 3'b000} : {pa[31:5], 5'b00000};
    for (int i = 0; i < 4; i++) begin
      exp_ba[i] = (exp_burst == 2'b10) ? {exp_araddr[31:5], 2'(exp_araddr[4:3] + i), 3'b000}
                                       : exp_araddr + 32'(8 * i);
    end
    exp_way      = '0;
    exp_way[vp]  = 1'b1;
    any_err      = (err_beat >= 0) && (err_beat < nb);
    install      = !unc && !any_err;
    if (!unc && Cwf) begin
      exp_rsp = (flush_beat != 0);
      exp_err = (err_beat == 0);
    end else begin
      exp_rsp = (flush_beat < 0);
      exp_err = any_err;
    end

    miss_paddr_i   = pa;
    miss_uncache_i = unc;
    miss_valid_i   = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(miss_ready_o && !flush_i) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("miss_accept", miss_ready_o, 1'b1);
    t_acc = cyc;
    @(posedge clk);
    #1;
    miss_valid_i = 1'b0;

    chk("arvalid", arvalid_o, 1'b1);
    chk("araddr", araddr_o, exp_araddr);
    chk("arlen", arlen_o, 8'(nb - 1));
    chk("arsize", arsize_o, 3'b011);
    chk("arburst", arburst_o, exp_burst);
    repeat (arw) begin
      @(posedge clk);
      #1;
    end
    chk("arvalid_hold", arvalid_o, 1'b1);
    arready_i = 1'b1;
    @(posedge clk);
    #1;
    arready_i = 1'b0;

    beat = 0;
    n    = 0;
    while (beat < nb && n < 200) begin
      rvalid_i = ($urandom_range(99) >= gap);
      rdata_i  = mem_word(exp_ba[beat]);
      rresp_i  = (beat == err_beat) ? 2'b10 : 2'b00;
      rlast_i  = (beat == nb - 1);
      flush_i  = rvalid_i && (beat == flush_beat);
      @(negedge clk);
      hs = rvalid_i && rready_o;
      @(posedge clk);
      #1;
      if (hs) beat++;
      n++;
    end
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
    rresp_i  = 2'b00;
    flush_i  = 1'b0;
    chk("beats_taken", beat, nb);

    n = 0;
    while (busy_o && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy_clear", busy_o, 1'b0);
    chk("ready_again", miss_ready_o, 1'b1);

    chk("n_data_wr", q_dw.size(), unc ? 0 : nb);
    if (!unc) begin
      for (int i = 0; i < nb && i < q_dw.size(); i++) begin
        chk("data_wr_way", q_dw[i].way, exp_way);
        chk("data_wr_addr", q_dw[i].addr, {pa[11:5], exp_ba[i][4:3]});
        chk("data_wr_data", q_dw[i].data, mem_word(exp_ba[i]));
      end
    end
    chk("n_tag_wr", q_tw.size(), install ? 1 : 0);
    if (install && q_tw.size() > 0) begin
      chk("tag_wr_way", q_tw[0].way, exp_way);
      chk("tag_wr_addr", q_tw[0].addr, pa[11:5]);
      chk("tag_wr_val", q_tw[0].tag, {1'b1, pa[31:12]});
    end
    chk("n_resp", q_rsp.size(), exp_rsp ? 1 : 0);
    if (exp_rsp && q_rsp.size() > 0) begin
      chk("resp_data", q_rsp[0].data, mem_word({pa[31:3], 3'b000}));
      chk("resp_err", q_rsp[0].err, exp_err);
      if (timing) chk("resp_latency", q_rsp[0].cyc - t_acc, (!unc && !Cwf) ? 7 : 3);
    end
    if (install) vp = (vp + 1) % WayNum;
  endtask

  initial begin
    logic [31:0] pa;
    bit          unc;
    int          eb, fb;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {miss_ready_o, busy_o, resp_valid_o, resp_err_o, arvalid_o, rready_o,
                       rf_data_we_o, rf_tag_we_o}, '0);
    chk("reset_ar", {araddr_o, arlen_o, arsize_o, arburst_o}, '0);
    chk("reset_resp_data", resp_data_o, '0);
    chk("reset_rf", {rf_data_addr_o, rf_tag_addr_o, rf_tag_o}, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", miss_ready_o, 1'b1);

    // Cached line, no wait states; then two more misses to the same set to walk the victim.
    run_miss(32'h1C00_0048, 1'b0, 0, 0, -1, -1, 1'b1);
    run_miss(32'h1C00_1048, 1'b0, 0, 0, -1, -1, 1'b1);
    run_miss(32'h1C00_2048, 1'b0, 1, 20, -1, -1, 1'b0);

    // Uncached single beat.
    run_miss(32'h1FE0_0004, 1'b1, 0, 0, -1, -1, 1'b1);

    // SLVERR on the third beat: line written, tag not installed, victim held.
    run_miss(32'h0000_3048, 1'b0, 0, 0, 2, -1, 1'b0);
    run_miss(32'h0000_4068, 1'b0, 0, 0, -1, -1, 1'b0);

    // Flush during beat 1 with R gaps.
    run_miss(32'h1C00_2060, 1'b0, 1, 30, -1, 1, 1'b0);

    // Flush together with the request: must not be accepted.
    miss_paddr_i   = 32'h0000_5000;
    miss_uncache_i = 1'b0;
    miss_valid_i   = 1'b1;
    flush_i        = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_blocks_accept", {busy_o, arvalid_o}, 2'b00);
    flush_i = 1'b0;
    run_miss(32'h0000_5000, 1'b0, 0, 0, -1, -1, 1'b1);

    // Fetch of word 3 in a line.
    run_miss(32'h2000_0058, 1'b0, 0, 0, -1, -1, 1'b1);

    for (int k = 0; k < 16; k++) begin
      pa  = $urandom();
      unc = ($urandom_range(3) == 0);
      eb  = ($urandom_range(4) == 0) ? int'($urandom_range(unc ? 0 : 3)) : -1;
      fb  = ($urandom_range(5) == 0) ? int'($urandom_range(unc ? 0 : 3)) : -1;
      run_miss(pa, unc, int'($urandom_range(2)), int'($urandom_range(40)), eb, fb, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
